// File: rtl/dm_load_align.sv
// Load-data return stage: captures load type/offset at MEM acceptance, then
// right-aligns and extends the SRAM read word, holding it across stalls.
module dm_load_align #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req_i,
  input  logic [2:0]            ld_funct3_i,
  input  logic [1:0]            DM_A_2b_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] DM_DO_i,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic                  ld_valid_o,
  output logic                  ld_misalign_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t                state_q;
  logic [2:0]            ld_type_q;
  logic [1:0]            ofs_q;
  logic [DATA_WIDTH-1:0] buf_q;

  logic                  accept;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;
  logic                  misalign;

  assign accept = ld_req_i & ~stall_i & ~flush_i;

  // State, captured load attributes and stall buffer; flush overrides all moves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_type_q <= 3'b000;
      ofs_q     <= 2'b00;
      buf_q     <= '0;
    end else begin
      if (accept) begin
        ld_type_q <= ld_funct3_i;
        ofs_q     <= DM_A_2b_i;
      end
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= accept ? DATA : IDLE;
          DATA: begin
            if (stall_i) begin
              state_q <= HELD;
              buf_q   <= DM_DO_i;
            end else begin
              state_q <= accept ? DATA : IDLE;
            end
          end
          HELD: begin
            if (!stall_i) state_q <= accept ? DATA : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Word select, byte shift and extension; missing upper bytes shift in as zero
  always_comb begin
    word     = '0;
    ext      = '0;
    misalign = 1'b0;
    case (state_q)
      DATA:    word = DM_DO_i;
      HELD:    word = buf_q;
      default: word = '0;
    endcase
    shifted = word >> {ofs_q, 3'b000};
    case (ld_type_q)
      F_LB:  ext = {{(DATA_WIDTH-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
      F_LBU: ext = {{(DATA_WIDTH-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
      F_LH:  ext = {{(DATA_WIDTH-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
      F_LHU: ext = {{(DATA_WIDTH-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
      F_LW:  ext = shifted;
      default: ext = '0;
    endcase
    case (ld_type_q)
      F_LH, F_LHU: misalign = (ofs_q == 2'd3);
      F_LW:        misalign = (ofs_q != 2'd0);
      default:     misalign = 1'b0;
    endcase
  end

  assign ld_valid_o    = (state_q != IDLE);
  assign ld_data_o     = ld_valid_o ? ext : '0;
  assign ld_misalign_o = ld_valid_o & misalign;

endmodule
